conv_psum_accum: RTL and testbench

- Downstream of the kernel-window counter in the convolutional layer datapath.
- Accumulates signed MAC products across one kernel row. Closes the row on each ready_psum pulse. After `kernel` rows, emits one saturated output pixel.
- Output pixels are buffered in a small FIFO and drained through a valid/ready handshake to the feature-map writer.

---
 rtl/conv_pkg.sv | 15 +
 rtl/psum_out_fifo.sv | 45 ++++
 rtl/conv_psum_accum.sv | 77 +++++++
 tb/tb_conv_psum_accum.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, accumulator/state types and output saturation for the conv psum path.
package conv_pkg;
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_OUT_W = 16;
  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef enum logic {IDLE, RUN} state_t;
  // Clamp a sign-extended value into the signed range of a w-bit result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
endpackage

// File: rtl/psum_out_fifo.sv
// psum_out_fifo: synchronous FIFO for finished output pixels.
// Ports: clk, rst_n (async, active-low), clr (sync flush), push/din, pop/dout,
// level (occupied entries), full, empty. dout reads 0 while empty.
// A push while full is accepted only if a pop frees the head in the same cycle.
module psum_out_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      level <= level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/conv_psum_accum.sv
// conv_psum_accum: accumulates MAC products over K kernel rows and queues saturated pixels.
// Ports: clk, rst_n (async, active-low); load/kernel start a window sequence (kernel 0 idles);
// enable, prod_valid/prod_data, ready_psum from the upstream counter; out_valid/out_ready/out_data
// drain the pixel FIFO; fifo_level, sticky ovf_err (pixel dropped on full), busy.
// Build option: define RELU_EN to clamp negative pixels to 0 after saturation.
module conv_psum_accum import conv_pkg::*; #(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [2:0]                      kernel,
  input  logic                            enable,
  input  logic                            prod_valid,
  input  logic signed [PROD_W-1:0]        prod_data,
  input  logic                            ready_psum,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            ovf_err,
  output logic                            busy
);
  state_t state;
  logic [2:0] kernel_reg, row_cnt;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [OUT_W-1:0] pix, push_val;
  logic active, close, push, pop, full, empty;
  assign active = state == RUN && enable && !load;
  // A product coincident with ready_psum belongs to the closing row.
  assign sum = acc + (prod_valid ? {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data} : '0);
  assign close = ready_psum && row_cnt == kernel_reg - 3'd1;
  assign push = active && close;
  assign pop = out_valid && out_ready;
  assign pix = OUT_W'(sat(64'(sum), OUT_W));
`ifdef RELU_EN
  assign push_val = pix[OUT_W-1] ? '0 : pix;
`else
  assign push_val = pix;
`endif
  assign out_valid = !empty;
  assign busy = state == RUN && (acc != '0 || row_cnt != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      kernel_reg <= '0;
      acc <= '0;
      row_cnt <= '0;
      ovf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err | (push && full && !pop);
      if (load) begin
        state <= kernel != '0 ? RUN : IDLE;
        kernel_reg <= kernel;
        acc <= '0;
        row_cnt <= '0;
      end else if (active) begin
        acc <= close ? '0 : sum;
        row_cnt <= close ? '0 : row_cnt + 3'(ready_psum);
      end
    end
  psum_out_fifo #(.W(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(load),
    .push(push),
    .din(push_val),
    .pop(pop),
    .dout(out_data),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_conv_psum_accum.sv
// tb_conv_psum_accum: directed self-checking bench for conv_psum_accum (PROD_W widened to 18).
module tb_conv_psum_accum;
  logic clk = 1'b0;
  logic rst_n, load, enable, prod_valid, ready_psum, out_valid, out_ready, ovf_err, busy;
  logic [2:0] kernel, fifo_level;
  logic signed [17:0] prod_data;
  logic signed [15:0] out_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  conv_psum_accum #(.PROD_W(18), .ACC_W(24), .OUT_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .kernel(kernel), .enable(enable),
    .prod_valid(prod_valid), .prod_data(prod_data), .ready_psum(ready_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .ovf_err(ovf_err), .busy(busy)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic pv, input int d, input logic rp);
    prod_valid = pv;
    prod_data = 18'(d);
    ready_psum = rp;
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    ready_psum = 1'b0;
  endtask
  task automatic do_load(input int k);
    load = 1'b1;
    kernel = 3'(k);
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask
  task automatic pop1();
    out_ready = 1'b1;
    step(1'b0, 0, 1'b0);
    out_ready = 1'b0;
  endtask
  initial begin
    int relu_exp;
    int vals[5] = '{11, 22, 33, 44, 55};
    rst_n = 1'b0; load = 1'b0; kernel = '0; enable = 1'b1;
    prod_valid = 1'b0; prod_data = '0; ready_psum = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single K=3 window
    do_load(3);
    step(1, 1, 0); step(1, 2, 0); step(1, 3, 1);
    chk("win_busy_mid", busy, 1);
    step(1, 4, 0); step(1, 5, 0); step(1, 6, 1);
    chk("win_level_mid", fifo_level, 0);
    step(1, 7, 0); step(1, 8, 0); step(1, 9, 1);
    chk("win_valid", out_valid, 1);
    chk("win_data", out_data, 45);
    chk("win_level", fifo_level, 1);
    chk("win_busy_end", busy, 0);
    pop1();
    chk("win_popped", fifo_level, 0);
    // coincident product and close, K=2
    do_load(2);
    step(1, 10, 0); step(1, 5, 1);
    chk("coin_level_mid", fifo_level, 0);
    step(1, 7, 1);
    chk("coin_data", out_data, 22);
    chk("coin_level", fifo_level, 1);
    pop1();
    // saturation, K=1
    do_load(1);
    step(1, 32767, 1);
    chk("sat_a", out_data, 32767);
    pop1();
    step(1, 32767, 1);
    chk("sat_b", out_data, 32767);
    pop1();
    step(1, 40000, 1);
    chk("sat_pos", out_data, 32767);
    pop1();
    step(1, -40000, 1);
    chk("sat_neg", out_data, -32768);
    pop1();
    do_load(2);
    step(1, 32767, 1); step(1, 32767, 1);
    chk("sat_sum", out_data, 32767);
    pop1();
    // relu build option
    do_load(1);
    step(1, -5, 1);
`ifdef RELU_EN
    relu_exp = 0;
`else
    relu_exp = -5;
`endif
    chk("relu", out_data, relu_exp);
    pop1();
    // backpressure and overflow
    for (int i = 0; i < 5; i++) step(1, vals[i], 1);
    chk("bp_level", fifo_level, 4);
    chk("bp_ovf", ovf_err, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_head%0d", i), out_data, vals[i]);
      pop1();
    end
    chk("bp_empty", out_valid, 0);
    chk("bp_ovf_sticky", ovf_err, 1);
    // push and pop together while full
    do_load(1);
    chk("load_keeps_ovf", ovf_err, 1);
    for (int i = 0; i < 4; i++) step(1, vals[i], 1);
    out_ready = 1'b1;
    step(1, 99, 1);
    out_ready = 1'b0;
    chk("full_pp_level", fifo_level, 4);
    chk("full_pp_head", out_data, 22);
    // enable gating
    do_load(2);
    chk("load_flush", fifo_level, 0);
    step(1, 3, 0);
    enable = 1'b0;
    step(1, 100, 0);
    enable = 1'b1;
    step(0, 0, 1); step(1, 4, 1);
    chk("en_data", out_data, 7);
    enable = 1'b0;
    pop1();
    chk("en_drain", fifo_level, 0);
    enable = 1'b1;
    // load mid-window
    step(1, 1, 1); step(1, 1, 1);
    chk("mid_first", out_data, 2);
    step(1, 1, 1); step(1, 1, 0);
    do_load(2);
    chk("mid_level", fifo_level, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    step(1, 6, 1);
    chk("mid_row_clr", fifo_level, 0);
    step(0, 0, 1);
    chk("mid_data", out_data, 6);
    // kernel 0 goes idle
    do_load(0);
    step(1, 9, 1); step(1, 9, 1); step(1, 9, 1);
    chk("idle_level", fifo_level, 0);
    chk("idle_busy", busy, 0);
    // reset mid-window
    do_load(2);
    step(1, 5, 1);
    #2;
    rst_n = 1'b0;
    #3;
    chk("rst2_ovf", ovf_err, 0);
    chk("rst2_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 5, 1);
    chk("rst2_idle", fifo_level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
